// File: rtl/nic_chan_pkg.sv
// rtl/nic_chan_pkg.sv - channel / flow-control field layout and injector state type
//
// Purpose: shared constants for the NIC injector slice.
// Field positions are counted from the MSB of each word: position k of a
// W-bit word is vector bit W-1-k. MSB-first literals such as 3'b101 therefore
// read field-for-field as the router documents them (valid, then vc).
package nic_chan_pkg;

  localparam int DATA_WIDTH_DEF  = 64;

  // channel_in_ip_N field positions
  localparam int CH_VALID        = 0;
  localparam int CH_HEAD         = 1;
  localparam int CH_TAIL         = 2;
  localparam int CH_VC_LSB       = 3;
  localparam int CH_RSVD         = 5;
  localparam int CH_DATA_LSB     = 6;
  localparam int VC_FIELD_WIDTH  = 2;
  localparam int CHANNEL_WIDTH   = DATA_WIDTH_DEF + CH_DATA_LSB;

  // flow_ctrl_out_ip_N field positions
  localparam int FC_VALID        = 0;
  localparam int FC_VC_LSB       = 1;
  localparam int FLOW_CTRL_WIDTH = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } inj_state_e;

endpackage

// File: rtl/nic_credit_counter.sv
// rtl/nic_credit_counter.sv - per-VC downstream buffer credit counter
//
// Purpose: tracks free slots of one downstream VC buffer.
// Ports:
//   clk, reset  clock, synchronous active-high reset (count -> BUF_DEPTH)
//   dec         a flit was sent on this VC
//   inc         a credit came back for this VC
//   count       current credits
//   nonzero     count > 0
//   full        count == BUF_DEPTH (buffer fully drained)
//   overflow    credit arrived while full with no same-cycle send
module nic_credit_counter #(
  parameter int BUF_DEPTH = 8,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             overflow
);

  assign full     = (count == CNT_W'(BUF_DEPTH));
  assign nonzero  = (count != '0);
  assign overflow = inc && !dec && full;

  // dec is only ever asserted with nonzero set, so no underflow guard is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CNT_W'(BUF_DEPTH);
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end else if (inc && !dec && !full) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nic_flit_injector.sv
// rtl/nic_flit_injector.sv - NIC transmit side driving one router injection port
//
// Purpose: accepts host flits, assigns each packet a VC round-robin, drives
// channel_out one cycle after acceptance and consumes per-VC credits.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_flit_*       host flit stream (valid/ready, head, tail, data)
//   channel_out     registered channel word: valid, head, tail, vc[2], rsvd, data
//   flow_ctrl_in    credit return: valid, vc[2]
//   busy            packet in progress
//   error           sticky protocol / credit error
module nic_flit_injector
  import nic_chan_pkg::*;
#(
  parameter int NUM_VCS         = 4,
  parameter int BUF_DEPTH       = 8,
  parameter int DATA_WIDTH      = 64,
  parameter bit ATOMIC_VC_ALLOC = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_flit_valid,
  output logic                         in_flit_ready,
  input  logic                         in_flit_head,
  input  logic                         in_flit_tail,
  input  logic [DATA_WIDTH-1:0]        in_flit_data,
  output logic [DATA_WIDTH+5:0]        channel_out,
  input  logic [FLOW_CTRL_WIDTH-1:0]   flow_ctrl_in,
  output logic                         busy,
  output logic                         error
);

  localparam int VC_W  = $clog2(NUM_VCS);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  inj_state_e            state, state_nxt;
  logic [VC_W-1:0]       cur_vc, rr_ptr, pick, send_vc;
  logic                  any_eligible, xfer, send, drop;
  logic [NUM_VCS-1:0]    eligible, nonzero, full, overflow, dec, inc;
  logic [CNT_W-1:0]      credit [NUM_VCS];

  logic                  fc_valid;
  logic [VC_W-1:0]       fc_vc;

  assign fc_valid = flow_ctrl_in[FLOW_CTRL_WIDTH-1-FC_VALID];
  assign fc_vc    = flow_ctrl_in[VC_W-1:0];

  genvar v;
  generate
    for (v = 0; v < NUM_VCS; v++) begin : g_vc
      assign eligible[v] = ATOMIC_VC_ALLOC ? full[v] : nonzero[v];
      assign dec[v]      = send && (send_vc == VC_W'(v));
      assign inc[v]      = fc_valid && (fc_vc == VC_W'(v));

      nic_credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .dec      (dec[v]),
        .inc      (inc[v]),
        .count    (credit[v]),
        .nonzero  (nonzero[v]),
        .full     (full[v]),
        .overflow (overflow[v])
      );
    end
  endgenerate

  // Round-robin: first eligible VC at or above rr_ptr, wrapping.
  always_comb begin
    pick         = '0;
    any_eligible = 1'b0;
    for (int i = 0; i < NUM_VCS; i++) begin
      int unsigned j;
      j = (int'(rr_ptr) + i) % NUM_VCS;
      if (!any_eligible && eligible[j]) begin
        any_eligible = 1'b1;
        pick         = VC_W'(j);
      end
    end
  end

  // Flits that will be dropped need no credit, so they never stall the host.
  always_comb begin
    state_nxt     = state;
    in_flit_ready = 1'b0;
    send          = 1'b0;
    drop          = 1'b0;
    send_vc       = cur_vc;
    xfer          = 1'b0;
    case (state)
      IDLE: begin
        in_flit_ready = any_eligible || !in_flit_head;
        send_vc       = pick;
        xfer          = in_flit_valid && in_flit_ready;
        send          = xfer && in_flit_head;
        drop          = xfer && !in_flit_head;
        if (send && !in_flit_tail) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        in_flit_ready = nonzero[cur_vc] || in_flit_head;
        xfer          = in_flit_valid && in_flit_ready;
        send          = xfer && !in_flit_head;
        drop          = xfer && in_flit_head;
        if (send && in_flit_tail) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_vc      <= '0;
      rr_ptr      <= '0;
      channel_out <= '0;
      error       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (send && state == IDLE) begin
        cur_vc <= pick;
        rr_ptr <= (pick == VC_W'(NUM_VCS - 1)) ? '0 : pick + VC_W'(1);
      end
      if (send) begin
        channel_out <= {1'b1, in_flit_head, in_flit_tail,
                        VC_FIELD_WIDTH'(send_vc), 1'b0, in_flit_data};
      end else begin
        channel_out <= '0;
      end
      if (drop || (|overflow)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nic_flit_injector.sv
// tb/tb_nic_flit_injector.sv - directed self-checking bench for nic_flit_injector
module tb_nic_flit_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_flit_valid;
  logic        in_flit_ready;
  logic        in_flit_head;
  logic        in_flit_tail;
  logic [63:0] in_flit_data;
  logic [69:0] channel_out;
  logic [2:0]  flow_ctrl_in;
  logic        busy;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  nic_flit_injector #(
    .NUM_VCS(4), .BUF_DEPTH(8), .DATA_WIDTH(64), .ATOMIC_VC_ALLOC(1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_flit_valid (in_flit_valid),
    .in_flit_ready (in_flit_ready),
    .in_flit_head  (in_flit_head),
    .in_flit_tail  (in_flit_tail),
    .in_flit_data  (in_flit_data),
    .channel_out   (channel_out),
    .flow_ctrl_in  (flow_ctrl_in),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel word: valid, head, tail, vc[2], rsvd, data[64] from MSB down.
  function automatic logic [69:0] flit(input logic h, input logic t,
                                       input logic [1:0] vc, input logic [63:0] d);
    return {1'b1, h, t, vc, 1'b0, d};
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    in_flit_valid = 1'b0;
    in_flit_head  = 1'b0;
    in_flit_tail  = 1'b0;
    in_flit_data  = '0;
    flow_ctrl_in  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents one flit, waits (bounded) for acceptance, returns at edge+1.
  task automatic xfer(input logic h, input logic t, input logic [63:0] d, input logic [2:0] fc);
    int n;
    n             = 0;
    in_flit_valid = 1'b1;
    in_flit_head  = h;
    in_flit_tail  = t;
    in_flit_data  = d;
    flow_ctrl_in  = fc;
    #1;
    while (!in_flit_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("xfer_timeout", 70'd0, 70'd1);
    @(posedge clk);
    #1;
    in_flit_valid = 1'b0;
    flow_ctrl_in  = '0;
  endtask

  task automatic credit_pulse(input logic [2:0] fc);
    flow_ctrl_in = fc;
    @(posedge clk);
    #1 flow_ctrl_in = '0;
  endtask

  initial begin
    // 1: reset defaults
    do_reset();
    #1;
    check("rst_chan",  channel_out, 70'd0);
    check("rst_ready", in_flit_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_error", error, 0);
    check("rst_cr0", dut.g_vc[0].u_cnt.count, 8);
    check("rst_cr1", dut.g_vc[1].u_cnt.count, 8);
    check("rst_cr2", dut.g_vc[2].u_cnt.count, 8);
    check("rst_cr3", dut.g_vc[3].u_cnt.count, 8);

    // 2: three-flit packet on vc0
    do_reset();
    xfer(1'b1, 1'b0, 64'hA0, 3'b000);
    check("t2_head", channel_out, flit(1'b1, 1'b0, 2'd0, 64'hA0));
    check("t2_busy1", busy, 1);
    xfer(1'b0, 1'b0, 64'hA1, 3'b000);
    check("t2_body", channel_out, flit(1'b0, 1'b0, 2'd0, 64'hA1));
    xfer(1'b1 ^ 1'b1, 1'b1, 64'hA2, 3'b000);
    check("t2_tail", channel_out, flit(1'b0, 1'b1, 2'd0, 64'hA2));
    check("t2_busy0", busy, 0);
    check("t2_cr0", dut.g_vc[0].u_cnt.count, 5);
    @(posedge clk);
    #1 check("t2_idle_chan", channel_out, 70'd0);

    // 3: ten-flit packet exhausts credits, one returned credit releases one flit
    do_reset();
    for (int i = 0; i < 8; i++) xfer(i == 0, 1'b0, 64'(i), 3'b000);
    check("t3_flit8", channel_out, flit(1'b0, 1'b0, 2'd0, 64'd7));
    check("t3_cr0_empty", dut.g_vc[0].u_cnt.count, 0);
    in_flit_valid = 1'b1;
    in_flit_head  = 1'b0;
    in_flit_tail  = 1'b0;
    in_flit_data  = 64'd8;
    #1 check("t3_stall_ready", in_flit_ready, 0);
    @(posedge clk);
    #1 check("t3_stall_chan", channel_out, 70'd0);
    flow_ctrl_in = 3'b100;
    #1 check("t3_no_comb_credit", in_flit_ready, 0);
    @(posedge clk);
    #1 flow_ctrl_in = '0;
    #1 check("t3_ready_after_credit", in_flit_ready, 1);
    @(posedge clk);
    #1 check("t3_flit9", channel_out, flit(1'b0, 1'b0, 2'd0, 64'd8));
    in_flit_valid = 1'b0;
    credit_pulse(3'b100);
    xfer(1'b0, 1'b1, 64'd9, 3'b000);
    check("t3_flit10", channel_out, flit(1'b0, 1'b1, 2'd0, 64'd9));
    check("t3_busy0", busy, 0);

    // 4: round-robin VC allocation
    do_reset();
    xfer(1'b1, 1'b1, 64'hB0, 3'b000);
    check("t4_pkt1_vc0", channel_out, flit(1'b1, 1'b1, 2'd0, 64'hB0));
    xfer(1'b1, 1'b1, 64'hB1, 3'b000);
    check("t4_pkt2_vc1", channel_out, flit(1'b1, 1'b1, 2'd1, 64'hB1));
    credit_pulse(3'b100);
    credit_pulse(3'b101);
    xfer(1'b1, 1'b1, 64'hB2, 3'b000);
    check("t4_pkt3_vc2", channel_out, flit(1'b1, 1'b1, 2'd2, 64'hB2));
    check("t4_error", error, 0);

    // 5: send and credit on the same VC in the same cycle
    do_reset();
    xfer(1'b1, 1'b1, 64'hC0, 3'b000);
    xfer(1'b1, 1'b1, 64'hC1, 3'b101);
    check("t5_vc1_flit", channel_out, flit(1'b1, 1'b1, 2'd1, 64'hC1));
    check("t5_cr1", dut.g_vc[1].u_cnt.count, 8);
    check("t5_error", error, 0);

    // 6: body flit in IDLE, credit overflow, sticky error
    do_reset();
    xfer(1'b0, 1'b0, 64'hD0, 3'b000);
    check("t6_drop_chan", channel_out, 70'd0);
    check("t6_error_set", error, 1);
    credit_pulse(3'b111);
    check("t6_cr3_sat", dut.g_vc[3].u_cnt.count, 8);
    @(posedge clk);
    #1 check("t6_error_sticky", error, 1);
    do_reset();
    #1 check("t6_error_cleared", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
